dmem_arbiter: RTL

//  Two-requester arbiter/sequencer in front of the single-port data_memory.

---
 rtl/dmem_arbiter_if.sv | 39 +++
 rtl/dmem_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter_if
//  Description : Request/response bundle for one requester of dmem_arbiter.
//                The request channel (req_valid/req_ready) carries a byte
//                address, store data, a store flag and the RISC-V funct3.
//                The response channel (rsp_valid/rsp_ready) returns the
//                extended load data and an error flag.
//  Ports       : master - requester side (drives request, consumes response)
//                slave  - arbiter side  (accepts request, drives response)
//  Revision    : 1.0 - initial release
// ============================================================================
interface dmem_arbiter_if #(
  parameter int DATA_WIDTH = 64
) ();

  logic                  req_valid;
  logic                  req_ready;
  logic [DATA_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  we;
  logic [2:0]            funct3;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, addr, wdata, we, funct3, rsp_ready,
    input  req_ready, rsp_valid, rdata, rsp_err
  );

  modport slave (
    input  req_valid, addr, wdata, we, funct3, rsp_ready,
    output req_ready, rsp_valid, rdata, rsp_err
  );

endinterface
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter
//  Description : Two-requester arbiter/sequencer in front of the single-port
//                data memory. Port 0 is the core LSU, port 1 the debug/loader
//                port. One transaction is in flight at a time and walks
//                IDLE -> ACCESS -> RESP -> IDLE. Misaligned, out-of-range and
//                illegal-funct3 accesses are answered with an error and never
//                reach the memory write enable.
//  Ports       : clk          - clock
//                rst_n        - asynchronous active-low reset
//                p0_if, p1_if - requester bundles (slave side)
//                mem_addr_o   - byte address to data memory
//                mem_wdata_o  - store data to data memory
//                mem_we_o     - one-cycle write enable to data memory
//                mem_funct3_o - access size/extension to data memory
//                mem_rdata_i  - combinational read data from data memory
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
  parameter int DATA_WIDTH    = 64,
  parameter int MEM_ADDR_BITS = 10,
  parameter int MAX_WAIT      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  dmem_arbiter_if.slave         p0_if,
  dmem_arbiter_if.slave         p1_if,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic                  mem_we_o,
  output logic [2:0]            mem_funct3_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  localparam int               WAIT_W     = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] c_max_wait = WAIT_W'(MAX_WAIT);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  state_e                state_q,      state_d;
  logic [WAIT_W-1:0]     wait_cnt_q,   wait_cnt_d;
  logic [DATA_WIDTH-1:0] hold_addr_q,  hold_addr_d;
  logic [DATA_WIDTH-1:0] hold_wdata_q, hold_wdata_d;
  logic                  hold_we_q,    hold_we_d;
  logic [2:0]            hold_f3_q,    hold_f3_d;
  logic                  hold_port_q,  hold_port_d;
  logic                  hold_err_q,   hold_err_d;
  logic [DATA_WIDTH-1:0] rdata_q,      rdata_d;

  logic                  w_idle;
  logic                  w_p1_win;
  logic                  w_p0_win;
  logic                  w_accept;
  logic                  w_accept_p1;
  logic [DATA_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_wdata;
  logic                  w_sel_we;
  logic [2:0]            w_sel_f3;
  logic                  w_sel_err;
  logic                  w_p0_rsp;
  logic                  w_p1_rsp;
  logic                  w_rsp_done;

  // Rejects an access that must not touch memory: misaligned for its size,
  // beyond the backing memory, or an encoding with no defined meaning.
  function automatic logic f_access_err(
    input logic [DATA_WIDTH-1:0] addr,
    input logic                  we,
    input logic [2:0]            f3
  );
    logic misaligned;
    logic out_of_range;
    logic bad_f3;
    misaligned = 1'b0;
    case (f3[1:0])
      2'b01:   misaligned = addr[0];
      2'b10:   misaligned = |addr[1:0];
      2'b11:   misaligned = |addr[2:0];
      default: misaligned = 1'b0;
    endcase
    out_of_range = |addr[DATA_WIDTH-1:MEM_ADDR_BITS];
    bad_f3       = we ? f3[2] : (f3 == 3'b111);
    return misaligned | out_of_range | bad_f3;
  endfunction

  // Port 0 normally wins; port 1 takes over when port 0 is idle or once
  // port 1 has been kept waiting for MAX_WAIT cycles.
  assign w_idle      = (state_q == ST_IDLE);
  assign w_p1_win    = p1_if.req_valid & (~p0_if.req_valid | (wait_cnt_q == c_max_wait));
  assign w_p0_win    = p0_if.req_valid & ~w_p1_win;
  assign w_accept    = w_idle & (w_p0_win | w_p1_win);
  assign w_accept_p1 = w_idle & w_p1_win;

  assign p0_if.req_ready = w_idle & w_p0_win;
  assign p1_if.req_ready = w_idle & w_p1_win;

  assign w_sel_addr  = w_p1_win ? p1_if.addr   : p0_if.addr;
  assign w_sel_wdata = w_p1_win ? p1_if.wdata  : p0_if.wdata;
  assign w_sel_we    = w_p1_win ? p1_if.we     : p0_if.we;
  assign w_sel_f3    = w_p1_win ? p1_if.funct3 : p0_if.funct3;
  assign w_sel_err   = f_access_err(w_sel_addr, w_sel_we, w_sel_f3);

  // Response is presented only to the port that owns the transaction;
  // the other port sees zeros so no data leaks across requesters.
  assign w_p0_rsp   = (state_q == ST_RESP) & ~hold_port_q;
  assign w_p1_rsp   = (state_q == ST_RESP) &  hold_port_q;
  assign w_rsp_done = (w_p0_rsp & p0_if.rsp_ready) | (w_p1_rsp & p1_if.rsp_ready);

  assign p0_if.rsp_valid = w_p0_rsp;
  assign p1_if.rsp_valid = w_p1_rsp;
  assign p0_if.rdata     = w_p0_rsp ? rdata_q : '0;
  assign p1_if.rdata     = w_p1_rsp ? rdata_q : '0;
  assign p0_if.rsp_err   = w_p0_rsp & hold_err_q;
  assign p1_if.rsp_err   = w_p1_rsp & hold_err_q;

  // The hold registers only change at accept, so the memory bus keeps its
  // last values outside ACCESS; the write strobe is confined to ACCESS and
  // follows the state register, which makes it drop with an async reset.
  assign mem_addr_o   = hold_addr_q;
  assign mem_wdata_o  = hold_wdata_q;
  assign mem_funct3_o = hold_f3_q;
  assign mem_we_o     = hold_we_q & ~hold_err_q & (state_q == ST_ACCESS);

  // Starvation counter for port 1: runs in every state while port 1 waits.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!p1_if.req_valid || w_accept_p1) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != c_max_wait) begin
      wait_cnt_d = wait_cnt_q + WAIT_W'(1);
    end
  end

  always_comb begin
    state_d      = state_q;
    hold_addr_d  = hold_addr_q;
    hold_wdata_d = hold_wdata_q;
    hold_we_d    = hold_we_q;
    hold_f3_d    = hold_f3_q;
    hold_port_d  = hold_port_q;
    hold_err_d   = hold_err_q;
    rdata_d      = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (w_accept) begin
          hold_addr_d  = w_sel_addr;
          hold_wdata_d = w_sel_wdata;
          hold_we_d    = w_sel_we;
          hold_f3_d    = w_sel_f3;
          hold_port_d  = w_p1_win;
          hold_err_d   = w_sel_err;
          state_d      = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        rdata_d = (hold_we_q | hold_err_q) ? '0 : mem_rdata_i;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (w_rsp_done) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      wait_cnt_q   <= '0;
      hold_addr_q  <= '0;
      hold_wdata_q <= '0;
      hold_we_q    <= 1'b0;
      hold_f3_q    <= 3'b000;
      hold_port_q  <= 1'b0;
      hold_err_q   <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      hold_addr_q  <= hold_addr_d;
      hold_wdata_q <= hold_wdata_d;
      hold_we_q    <= hold_we_d;
      hold_f3_q    <= hold_f3_d;
      hold_port_q  <= hold_port_d;
      hold_err_q   <= hold_err_d;
      rdata_q      <= rdata_d;
    end
  end

endmodule
`default_nettype wire
